pixel_stream_source: RTL and testbench

- AXI4-Stream frame transmitter: reads a raw greyscale frame from a synchronous single-port frame-buffer read interface and emits it pixel by pixel on an AXI4-Stream master.
- Output uses the same framing the filter's slave stream consumes: tuser marks the last pixel of each line (EOL), tlast marks the last pixel of the frame.
- Sits upstream of the filter's s_axis port. Used as the on-chip frame source and as the stimulus driver in system benches.

---
 rtl/pixel_stream_source.sv | 147 ++++++++++++++
 tb/tb_pixel_stream_source.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_stream_source.sv
// Streams a WIDTH x HEIGHT greyscale frame from a 1-cycle-latency frame-buffer read port
// onto an AXI4-Stream master, with tuser marking end-of-line and tlast marking end-of-frame.
module pixel_stream_source #(
    parameter int unsigned DATA_WIDTH             = 8,
    parameter int unsigned IMAGE_WIDTH_SIZE       = 512,
    parameter int unsigned IMAGE_WIDTH_LOG2_SIZE  = 9,
    parameter int unsigned IMAGE_HEIGHT_SIZE      = 512,
    parameter int unsigned IMAGE_HEIGHT_LOG2_SIZE = 9,
    parameter int unsigned ADDR_WIDTH             = 18
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  mem_rd_en_o,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr_o,
    input  logic [DATA_WIDTH-1:0] mem_rd_data_i,
    output logic                  m_axis_tvalid_o,
    output logic [DATA_WIDTH-1:0] m_axis_tdata_o,
    input  logic                  m_axis_tready_i,
    output logic                  m_axis_tuser_o,
    output logic                  m_axis_tlast_o
);

    localparam int unsigned NumPix = IMAGE_WIDTH_SIZE * IMAGE_HEIGHT_SIZE;
    localparam int unsigned EntryW = DATA_WIDTH + 2;
    localparam int unsigned ColW   = IMAGE_WIDTH_LOG2_SIZE;
    localparam int unsigned RowW   = IMAGE_HEIGHT_LOG2_SIZE;

    localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(NumPix - 1);
    localparam logic [ColW-1:0]       LastCol  = ColW'(IMAGE_WIDTH_SIZE - 1);
    localparam logic [RowW-1:0]       LastRow  = RowW'(IMAGE_HEIGHT_SIZE - 1);

    typedef enum logic [1:0] {StIdle, StStream, StDrain, StDone} state_e;

    state_e state_q, state_d;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ColW-1:0]       col_q;
    logic [RowW-1:0]       row_q;

    // One-cycle tag pipeline that travels alongside each outstanding read.
    logic rd_vld_q, rd_user_q, rd_last_q;

    logic [EntryW-1:0] fifo_q [0:2];
    logic [1:0]        wr_ptr_q, rd_ptr_q, count_q;

    logic issue, push, pop, eol, eof, last_issue;
    logic [EntryW-1:0] head;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Registered occupancy only, so tready never reaches mem_rd_en combinationally.
    assign issue      = (state_q == StStream) &&
                        (({1'b0, count_q} + {2'b00, rd_vld_q}) < 3'd3);
    assign push       = rd_vld_q;
    assign pop        = (count_q != 2'd0) && m_axis_tready_i;
    assign eol        = (col_q == LastCol);
    assign eof        = eol && (row_q == LastRow);
    assign last_issue = issue && (addr_q == LastAddr);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (start_i) state_d = StStream;
            StStream: if (last_issue) state_d = StDrain;
            // Leave as the final beat hands off so done lands the cycle after tlast.
            StDrain:  if (!rd_vld_q && ((count_q == 2'd0) || ((count_q == 2'd1) && pop)))
                          state_d = StDone;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        busy_o      = (state_q == StStream) || (state_q == StDrain);
        done_o      = (state_q == StDone);
        mem_rd_en_o = issue;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q    <= '0;
            col_q     <= '0;
            row_q     <= '0;
            rd_vld_q  <= 1'b0;
            rd_user_q <= 1'b0;
            rd_last_q <= 1'b0;
        end else begin
            if ((state_q == StIdle) && start_i) begin
                addr_q <= '0;
                col_q  <= '0;
                row_q  <= '0;
            end else if (issue) begin
                addr_q <= addr_q + 1'b1;
                if (eol) begin
                    col_q <= '0;
                    row_q <= row_q + 1'b1;
                end else begin
                    col_q <= col_q + 1'b1;
                end
            end
            rd_vld_q  <= issue;
            rd_user_q <= eol;
            rd_last_q <= eof;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 3; i++) fifo_q[i] <= '0;
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= {mem_rd_data_i, rd_user_q, rd_last_q};
                wr_ptr_q         <= ptr_inc(wr_ptr_q);
            end
            if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign head            = fifo_q[rd_ptr_q];
    assign m_axis_tvalid_o = (count_q != 2'd0);
    assign m_axis_tdata_o  = head[EntryW-1:2];
    assign m_axis_tuser_o  = head[1];
    assign m_axis_tlast_o  = head[0];
    assign mem_rd_addr_o   = addr_q;

endmodule

// File: tb/tb_pixel_stream_source.sv
// Scoreboard bench for pixel_stream_source: a 4x3 frame under several tready patterns,
// restart/reset corner cases, and a 1x1 degenerate instance.
module tb_pixel_stream_source;

    localparam int W = 4;
    localparam int H = 3;
    localparam int N = W * H;

    typedef struct packed {
        logic [7:0] d;
        logic       u;
        logic       l;
    } beat_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0, busy, done, rd_en;
    logic [3:0] rd_addr;
    logic [7:0] rd_data, tdata;
    logic       tvalid, tready = 1'b1, tuser, tlast;

    logic       start1 = 1'b0, busy1, done1, rd_en1;
    logic [0:0] rd_addr1;
    logic [7:0] rd_data1, tdata1;
    logic       tvalid1, tready1 = 1'b1, tuser1, tlast1;

    logic [7:0] mem [N];
    logic [7:0] mem1;

    beat_t exp_q[$];
    int    total = 0, bad = 0;
    int    cyc = 0, t0 = 0, clear_req = 0, tr_mode = 0;
    int    exp_addr = 0, issued = 0, consumed = 0, first_rd = -1, first_tv = -1;
    int    done_due = -1, done_rel = -1, frames = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (rd_en) rd_data <= (int'(rd_addr) < N) ? mem[rd_addr] : 8'h00;
    always @(posedge clk) if (rd_en1) rd_data1 <= mem1;

    pixel_stream_source #(
        .DATA_WIDTH(8), .IMAGE_WIDTH_SIZE(W), .IMAGE_WIDTH_LOG2_SIZE(2),
        .IMAGE_HEIGHT_SIZE(H), .IMAGE_HEIGHT_LOG2_SIZE(2), .ADDR_WIDTH(4)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .busy_o(busy), .done_o(done),
        .mem_rd_en_o(rd_en), .mem_rd_addr_o(rd_addr), .mem_rd_data_i(rd_data),
        .m_axis_tvalid_o(tvalid), .m_axis_tdata_o(tdata), .m_axis_tready_i(tready),
        .m_axis_tuser_o(tuser), .m_axis_tlast_o(tlast)
    );

    pixel_stream_source #(
        .DATA_WIDTH(8), .IMAGE_WIDTH_SIZE(1), .IMAGE_WIDTH_LOG2_SIZE(1),
        .IMAGE_HEIGHT_SIZE(1), .IMAGE_HEIGHT_LOG2_SIZE(1), .ADDR_WIDTH(1)
    ) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start1), .busy_o(busy1), .done_o(done1),
        .mem_rd_en_o(rd_en1), .mem_rd_addr_o(rd_addr1), .mem_rd_data_i(rd_data1),
        .m_axis_tvalid_o(tvalid1), .m_axis_tdata_o(tdata1), .m_axis_tready_i(tready1),
        .m_axis_tuser_o(tuser1), .m_axis_tlast_o(tlast1)
    );

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // tready generator: 0 always high, 1 pattern 1,0,0,1, 2 random, 3 held low
    initial begin
        logic [3:0] pat;
        int ph;
        pat = 4'b1001;
        ph  = 0;
        forever begin
            @(posedge clk);
            #1;
            case (tr_mode)
                0:       tready = 1'b1;
                1:       tready = pat[ph % 4];
                2:       tready = 1'($urandom % 2);
                default: tready = 1'b0;
            endcase
            ph++;
        end
    end

    // Monitor: checks addresses, outstanding reads, AXI hold rules, beats and done timing.
    initial begin
        int    seen;
        beat_t e;
        beat_t cur;
        logic  held;
        beat_t hold_v;
        seen = 0;
        held = 1'b0;
        hold_v = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                held     = 1'b0;
                done_due = -1;
                continue;
            end
            if (clear_req != seen) begin
                seen     = clear_req;
                exp_addr = 0;
                issued   = 0;
                consumed = 0;
                first_rd = -1;
                first_tv = -1;
                done_rel = -1;
            end
            if (rd_en) begin
                if (first_rd < 0) first_rd = cyc - t0;
                chk("rd_addr", int'(rd_addr), exp_addr);
                exp_addr++;
                issued++;
                chk("outstanding_le3", int'((issued - consumed) <= 3), 1);
            end
            cur = {tdata, tuser, tlast};
            if (held) begin
                chk("tvalid_hold", int'(tvalid), 1);
                chk("payload_hold", int'(cur), int'(hold_v));
            end
            if (tvalid) begin
                if (first_tv < 0) first_tv = cyc - t0;
                if (tready) begin
                    if (exp_q.size() == 0) begin
                        chk("extra_beat", int'(tdata), -1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("tdata", int'(tdata), int'(e.d));
                        chk("tuser", int'(tuser), int'(e.u));
                        chk("tlast", int'(tlast), int'(e.l));
                        if (e.l) done_due = cyc + 1;
                    end
                    consumed++;
                    held = 1'b0;
                end else begin
                    held   = 1'b1;
                    hold_v = cur;
                end
            end else begin
                held = 1'b0;
            end
            if (done || (cyc == done_due)) begin
                chk("done_timing", int'(done), int'(cyc == done_due));
                if (done) begin
                    chk("busy_low_at_done", int'(busy), 0);
                    done_rel = cyc - t0;
                    frames++;
                end
                done_due = -1;
            end
        end
    end

    task automatic fill(input bit rnd);
        for (int i = 0; i < N; i++) mem[i] = rnd ? 8'($urandom) : 8'(i);
    endtask

    task automatic accept();
        beat_t b;
        @(negedge clk);
        start = 1'b1;
        clear_req++;
        for (int i = 0; i < N; i++) begin
            b.d = mem[i];
            b.u = 1'((i % W) == (W - 1));
            b.l = 1'(i == N - 1);
            exp_q.push_back(b);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        t0 = cyc - 1;
    endtask

    task automatic wait_frames(input int target);
        int n;
        n = 0;
        while (frames < target && n < 400) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("frame_complete", int'(frames >= target), 1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_rd_en"}, int'(rd_en), 0);
        chk({tag, "_rd_addr"}, int'(rd_addr), 0);
        chk({tag, "_tvalid"}, int'(tvalid), 0);
        chk({tag, "_tdata"}, int'(tdata), 0);
        chk({tag, "_tuser"}, int'(tuser), 0);
        chk({tag, "_tlast"}, int'(tlast), 0);
    endtask

    initial begin
        int n;
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int n;
        #2 rst_n = 1'b0;
        #1;
        chk_all_zero("reset");
        chk("reset1_tvalid", int'(tvalid1), 0);
        chk("reset1_busy", int'(busy1), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Plain frame, data = address, tready high.
        tr_mode = 0;
        fill(0);
        accept();
        wait_frames(1);
        chk("first_rd_cycle", first_rd, 1);
        chk("first_tvalid_cycle", first_tv, 3);
        chk("done_cycle", done_rel, 15);
        chk("queue_empty_1", exp_q.size(), 0);

        // Periodic backpressure with random data.
        tr_mode = 1;
        fill(1);
        accept();
        wait_frames(2);
        chk("queue_empty_2", exp_q.size(), 0);

        // Long stall right from the first beat.
        tr_mode = 3;
        fill(0);
        accept();
        n = 0;
        while (!tvalid && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("stall_tvalid_seen", int'(tvalid), 1);
        repeat (20) @(negedge clk);
        #1;
        chk("stall_reads", issued, 3);
        chk("stall_tdata", int'(tdata), 0);
        tr_mode = 0;
        wait_frames(3);

        // Start during STREAM and during DONE is ignored; start right after DONE relaunches.
        tr_mode = 2;
        fill(1);
        accept();
        repeat (4) @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n = 0;
        while (!done && n < 400) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("done_seen_4", int'(done), 1);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("no_restart_after_done", int'(busy), 0);
        accept();
        wait_frames(5);

        // Reset mid-frame, then a fresh frame from address 0.
        tr_mode = 0;
        fill(1);
        accept();
        n = 0;
        while (consumed < 5 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("midframe_beats", int'(consumed >= 5), 1);
        #2 rst_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        fill(0);
        accept();
        wait_frames(6);
        chk("frames_total", frames, 6);
        chk("queue_empty_end", exp_q.size(), 0);

        // Degenerate 1x1 frame.
        mem1 = 8'($urandom);
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        #1 start1 = 1'b0;
        n = 0;
        while (!tvalid1 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("one_tvalid", int'(tvalid1), 1);
        chk("one_tdata", int'(tdata1), int'(mem1));
        chk("one_tuser", int'(tuser1), 1);
        chk("one_tlast", int'(tlast1), 1);
        @(negedge clk);
        #1;
        chk("one_done", int'(done1), 1);
        chk("one_busy_at_done", int'(busy1), 0);
        chk("one_single_beat", int'(tvalid1), 0);
        @(negedge clk);
        #1;
        chk("one_done_pulse", int'(done1), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
